// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: request/response control around an iterative 33x33 Booth multiplier.
// Optional MUL_ZERO_BYPASS_EN answers zero-operand requests without starting the multiplier.
module mul_issue_ctrl #(
   parameter int TAG_W = 4,
   parameter int XLEN  = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_op,
   input  logic [XLEN-1:0]     req_src1,
   input  logic [XLEN-1:0]     req_src2,
   input  logic [TAG_W-1:0]    req_tag,
   input  logic                flush,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [XLEN-1:0]     resp_data,
   output logic [TAG_W-1:0]    resp_tag,
   output logic                mul_in_valid,
   input  logic                mul_in_ready,
   output logic [XLEN:0]       mul_src1,
   output logic [XLEN:0]       mul_src2,
   input  logic                mul_out_valid,
   input  logic [2*XLEN-1:0]   mul_result
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_e;
   state_e            state_q;
   logic [1:0]        op_q;
   logic              mul_in_valid_q, resp_valid_q;
   logic [XLEN-1:0]   resp_data_q;
   logic [TAG_W-1:0]  resp_tag_q;
   logic [XLEN:0]     mul_src1_q, mul_src2_q, ext1_d, ext2_d;
   logic              accept, byp;
   assign req_ready = !flush && (state_q == IDLE || (state_q == RESP && resp_ready));
   assign accept = req_valid && req_ready;
   assign ext1_d = {req_op != 2'b11 && req_src1[XLEN-1], req_src1};
   assign ext2_d = {!req_op[1] && req_src2[XLEN-1], req_src2};
`ifdef MUL_ZERO_BYPASS_EN
   assign byp = (req_src1 == '0) || (req_src2 == '0);
`else
   assign byp = 1'b0;
`endif
   assign mul_in_valid = mul_in_valid_q;
   assign resp_valid = resp_valid_q;
   assign resp_data = resp_data_q;
   assign resp_tag = resp_tag_q;
   assign mul_src1 = mul_src1_q;
   assign mul_src2 = mul_src2_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         op_q <= '0;
         mul_in_valid_q <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q <= '0;
         resp_tag_q <= '0;
         mul_src1_q <= '0;
         mul_src2_q <= '0;
      end else begin
         if (accept) begin
            op_q <= req_op;
            resp_tag_q <= req_tag;
            mul_src1_q <= ext1_d;
            mul_src2_q <= ext2_d;
         end
         case (state_q)
            IDLE, RESP: begin
               if (accept) begin
                  state_q <= byp ? RESP : ISSUE;
                  mul_in_valid_q <= !byp;
                  resp_valid_q <= byp;
                  if (byp) resp_data_q <= '0;
               end else if (flush || state_q == IDLE || resp_ready) begin
                  state_q <= IDLE;
                  resp_valid_q <= 1'b0;
               end
            end
            ISSUE: begin
               if (flush || mul_in_ready) begin
                  mul_in_valid_q <= 1'b0;
                  state_q <= !mul_in_ready ? IDLE : flush ? DRAIN : WAIT;
               end
            end
            WAIT: begin
               // a flush coinciding with the done pulse has nothing left to drain
               if (mul_out_valid) begin
                  state_q <= flush ? IDLE : RESP;
                  resp_valid_q <= !flush;
                  resp_data_q <= (op_q == 2'b00) ? mul_result[XLEN-1:0] : mul_result[2*XLEN-1:XLEN];
               end else if (flush) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: if (mul_out_valid) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed plan items plus randomized traffic against a transaction-level model
// and a behavioural multiplier with random handshake and latency.
module tb_mul_issue_ctrl;
   logic        clk = 0, reset = 1, req_valid = 0, flush = 0, resp_ready = 0;
   logic        mul_in_ready = 0, mul_out_valid = 0;
   logic        req_ready, resp_valid, mul_in_valid;
   logic [1:0]  req_op = 0;
   logic [31:0] req_src1 = 0, req_src2 = 0, resp_data;
   logic [3:0]  req_tag = 0, resp_tag;
   logic [32:0] mul_src1, mul_src2;
   logic [63:0] mul_result = 0;
   int checks = 0, failures = 0;
   bit pending, issued, resp_exp, busy, slow, rsp_fire;
   int cnt;
   logic [31:0] exp_data, cur_a, cur_b;
   logic [3:0]  exp_tag;
   logic [1:0]  cur_op;
   logic [63:0] prod;
   logic signed [65:0] x1, x2, sp;

   mul_issue_ctrl #(.TAG_W(4), .XLEN(32)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag), .flush(flush),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
      .mul_in_valid(mul_in_valid), .mul_in_ready(mul_in_ready), .mul_src1(mul_src1), .mul_src2(mul_src2),
      .mul_out_valid(mul_out_valid), .mul_result(mul_result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] xa, xb, p;
      xa = (op == 2'd3) ? {32'b0, a} : {{32{a[31]}}, a};
      xb = op[1] ? {32'b0, b} : {{32{b[31]}}, b};
      p = xa * xb;
      return (op == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [32:0] ext(input logic s, input logic [31:0] v);
      return {s & v[31], v};
   endfunction

   function automatic logic [31:0] pick();
      int k;
      k = $urandom_range(0, 5);
      return (k == 0) ? 32'h0 : (k == 1) ? 32'hFFFF_FFFF : (k == 2) ? 32'h8000_0000 : (k == 3) ? 32'h1 : $urandom;
   endfunction

   // Model + multiplier: observe at negedge, drive multiplier outputs just after posedge
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            pending = 0; issued = 0; resp_exp = 0; busy = 0;
         end else begin
            chk("req_ready", req_ready, !flush && !(busy && !pending) && (!pending || (resp_exp && resp_ready)));
            chk("resp_valid", resp_valid, resp_exp);
            chk("mul_in_valid", mul_in_valid, pending && !issued && !resp_exp);
            if (resp_exp) begin
               chk("resp_data", resp_data, exp_data);
               chk("resp_tag", resp_tag, exp_tag);
            end
            if (mul_in_valid && mul_in_ready) begin
               chk("mul_src1", mul_src1, ext(cur_op != 2'd3, cur_a));
               chk("mul_src2", mul_src2, ext(!cur_op[1], cur_b));
               x1 = {{33{mul_src1[32]}}, mul_src1};
               x2 = {{33{mul_src2[32]}}, mul_src2};
               sp = x1 * x2;
               prod = sp[63:0];
               busy = 1; issued = 1;
               cnt = slow ? 12 : $urandom_range(0, 5);
            end
            rsp_fire = resp_valid && resp_ready && !flush;
            if (rsp_fire) begin pending = 0; resp_exp = 0; end
            if (flush) begin pending = 0; resp_exp = 0; end
            if (mul_out_valid) begin
               busy = 0;
               if (pending) resp_exp = 1;
            end
            if (req_valid && req_ready) begin
               pending = 1; issued = 0; resp_exp = 0;
               cur_op = req_op; cur_a = req_src1; cur_b = req_src2;
               exp_data = ref_mul(req_op, req_src1, req_src2);
               exp_tag = req_tag;
`ifdef MUL_ZERO_BYPASS_EN
               if (req_src1 == 0 || req_src2 == 0) begin resp_exp = 1; issued = 1; end
`endif
            end
         end
         @(posedge clk); #1;
         if (reset) begin
            busy = 0; mul_out_valid = 0; mul_in_ready = 0;
         end else begin
            mul_out_valid = 0;
            mul_result = {$urandom, $urandom};
            if (busy) begin
               if (cnt == 0) begin mul_out_valid = 1; mul_result = prod; end
               else cnt--;
            end
            mul_in_ready = !busy && ($urandom_range(0, 3) != 0);
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
      int n;
      n = 0;
      req_valid = 1; req_op = op; req_src1 = a; req_src2 = b; req_tag = tag;
      @(negedge clk);
      while (!req_ready && n < 100) begin n++; @(negedge clk); end
      if (n >= 100) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      req_valid = 0;
   endtask

   task automatic recv(input logic [31:0] exp);
      int n;
      n = 0;
      resp_ready = 1;
      @(negedge clk);
      while (!resp_valid && n < 100) begin n++; @(negedge clk); end
      if (n >= 100) chk("recv_timeout", 0, 1);
      else chk("plan_data", resp_data, exp);
      @(posedge clk); #1;
   endtask

   task automatic wait_mul_wait();
      int n;
      n = 0;
      @(negedge clk);
      while (!(busy && !mul_in_valid) && n < 50) begin n++; @(negedge clk); end
      if (n >= 50) chk("wait_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_mul_in_valid", mul_in_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_mul_src1", mul_src1, 0);
      repeat (2) @(posedge clk);
      #1 reset = 0;
      send(2'd0, 7, 6, 3);            recv(32'h0000_002A);
      send(2'd1, '1, '1, 1);          recv(32'h0000_0000);
      send(2'd3, '1, '1, 2);          recv(32'hFFFF_FFFE);
      send(2'd2, '1, '1, 4);          recv(32'hFFFF_FFFF);
      send(2'd0, 32'h8000_0000, 2, 5); recv(32'h0000_0000);
      // backpressure, then back-to-back acceptance on the response handshake
      resp_ready = 0;
      send(2'd0, 32'h1234, 32'h10, 9);
      wait_resp: for (int n = 0; n < 100 && !resp_valid; n++) @(negedge clk);
      repeat (5) begin
         @(negedge clk);
         chk("hold_valid", resp_valid, 1);
         chk("hold_data", resp_data, 32'h0001_2340);
         chk("hold_tag", resp_tag, 9);
      end
      @(posedge clk); #1;
      req_valid = 1; req_op = 2'd3; req_src1 = '1; req_src2 = 2; req_tag = 10; resp_ready = 1;
      @(negedge clk);
      chk("b2b_ready", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 0;
      @(negedge clk);
      chk("b2b_issue", mul_in_valid, 1);
      recv(32'h0000_0001);
      // flush while the multiplier is busy
      slow = 1;
      send(2'd0, 11, 13, 2);
      wait_mul_wait();
      @(posedge clk); #1;
      flush = 1; req_valid = 1; req_op = 2'd0; req_src1 = 3; req_src2 = 5; req_tag = 6;
      @(negedge clk);
      chk("flush_ready", req_ready, 0);
      @(posedge clk); #1;
      flush = 0; slow = 0;
      @(negedge clk);
      chk("drain_ready", req_ready, 0);
      @(posedge clk); #1;
      send(2'd0, 3, 5, 6);            recv(32'h0000_000F);
      // asynchronous reset in the middle of a multiply
      slow = 1;
      send(2'd0, 32'h1234, 32'h10, 5);
      wait_mul_wait();
      @(posedge clk); #3;
      reset = 1;
      #1;
      chk("arst_req_ready", req_ready, 1);
      chk("arst_resp_valid", resp_valid, 0);
      chk("arst_mul_in_valid", mul_in_valid, 0);
      chk("arst_resp_data", resp_data, 0);
      chk("arst_resp_tag", resp_tag, 0);
      chk("arst_mul_src1", mul_src1, 0);
      chk("arst_mul_src2", mul_src2, 0);
      repeat (2) @(posedge clk);
      #1 reset = 0; slow = 0;
`ifdef MUL_ZERO_BYPASS_EN
      resp_ready = 0;
      send(2'd0, 0, 9, 7);
      @(negedge clk);
      chk("byp_valid", resp_valid, 1);
      chk("byp_issue", mul_in_valid, 0);
      recv(32'h0);
`endif
      for (int i = 0; i < 400; i++) begin
         req_valid = 1'($urandom_range(0, 1));
         req_op = 2'($urandom_range(0, 3));
         req_src1 = pick();
         req_src2 = pick();
         req_tag = 4'($urandom);
         flush = ($urandom_range(0, 19) == 0);
         resp_ready = !flush && ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      req_valid = 0; flush = 0; resp_ready = 1;
      repeat (40) @(posedge clk);
      #1;
      chk("end_idle_ready", req_ready, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
